// File: rtl/txhex_fifo.sv
// txhex_fifo: small word FIFO in front of an ASCII-hex line printer.
// Each queued word is emitted as optional "0x", DW/4 hex digits (optionally
// zero-suppressed) and an optional line ending, one byte at a time over a
// stb/busy handshake to an external UART.
module txhex_fifo #(
  parameter int unsigned DW     = 32,
  parameter int unsigned LGFIFO = 2,
  parameter int unsigned PREFIX = 1,
  parameter int unsigned EOL    = 2,
  parameter int unsigned UPPER  = 0,
  parameter int unsigned ZSUPP  = 0
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_stb,
  input  logic [DW-1:0]     i_data,
  output logic              o_busy,
  output logic [LGFIFO:0]   o_fill,
  output logic              o_idle,
  output logic              o_tx_stb,
  output logic [7:0]        o_tx_data,
  input  logic              i_tx_busy
);

  localparam int unsigned DEPTH = 2 ** LGFIFO;
  localparam int unsigned ND    = DW / 4;
  localparam int unsigned CW    = (ND > 1) ? $clog2(ND) : 1;
  localparam logic [LGFIFO:0] FULL = (LGFIFO + 1)'(DEPTH);

  typedef enum logic [2:0] {StIdle, StP0, StP1, StDig, StCr, StLf} state_e;

  // Where the FSM goes once a word is popped and once its last digit is accepted.
  localparam state_e FirstSt  = (PREFIX != 0) ? StP0 : StDig;
  localparam state_e AfterDig = (EOL == 2) ? StCr : ((EOL == 1) ? StLf : StIdle);

  state_e            state, next_state;
  logic [DW-1:0]     mem [DEPTH];
  logic [LGFIFO-1:0] wr_ptr, rd_ptr;
  logic [LGFIFO:0]   fill;
  logic [DW-1:0]     sreg, sreg_next;
  logic [CW-1:0]     dcnt, dcnt_next;
  logic              skipping, skipping_next;
  logic              push, pop, accept, skip_now;
  logic [3:0]        nib;
  logic [7:0]        dig_char;

  assign o_busy = (fill == FULL);
  assign o_fill = fill;
  assign o_idle = (fill == '0) && (state == StIdle);

  // A push while full is dropped even if a pop frees a slot in the same cycle.
  assign push = i_stb && !o_busy;
  assign pop  = (state == StIdle) && (fill != '0);

  assign nib = sreg[DW-1 -: 4];

  // Leading zeros are skipped silently, but the final digit is always shown.
  assign skip_now = (state == StDig) && skipping && (nib == 4'h0) && (dcnt != '0);

  assign o_tx_stb = (state != StIdle) && !skip_now;
  assign accept   = o_tx_stb && !i_tx_busy;

  // Word storage; reads are gated by fill so no reset is needed.
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= i_data;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fill <= fill + 1'b1;
      else if (!push && pop) fill <= fill - 1'b1;
    end
  end

  // Printer state, shift register and digit counter.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state    <= StIdle;
      sreg     <= '0;
      dcnt     <= '0;
      skipping <= 1'b0;
    end else begin
      state    <= next_state;
      sreg     <= sreg_next;
      dcnt     <= dcnt_next;
      skipping <= skipping_next;
    end
  end

  // ASCII for the top nibble of the shift register.
  always_comb begin
    if (nib < 4'd10)       dig_char = 8'h30 + {4'h0, nib};
    else if (UPPER != 0)   dig_char = 8'h37 + {4'h0, nib};  // 'A' - 10
    else                   dig_char = 8'h57 + {4'h0, nib};  // 'a' - 10
  end

  // Current output byte; held stable by the state until accepted.
  always_comb begin
    o_tx_data = 8'h00;
    if (o_tx_stb) begin
      unique case (state)
        StP0:    o_tx_data = 8'h30;
        StP1:    o_tx_data = 8'h78;
        StDig:   o_tx_data = dig_char;
        StCr:    o_tx_data = 8'h0d;
        StLf:    o_tx_data = 8'h0a;
        default: o_tx_data = 8'h00;
      endcase
    end
  end

  // Next-state logic: advance only on accept, or one nibble per cycle while skipping.
  always_comb begin
    next_state    = state;
    sreg_next     = sreg;
    dcnt_next     = dcnt;
    skipping_next = skipping;
    unique case (state)
      StIdle: begin
        if (pop) begin
          sreg_next     = mem[rd_ptr];
          dcnt_next     = CW'(ND - 1);
          skipping_next = (ZSUPP != 0);
          next_state    = FirstSt;
        end
      end
      StP0: if (accept) next_state = StP1;
      StP1: if (accept) next_state = StDig;
      StDig: begin
        if (skip_now) begin
          sreg_next = sreg << 4;
          dcnt_next = dcnt - 1'b1;
        end else if (accept) begin
          skipping_next = 1'b0;
          if (dcnt == '0) begin
            next_state = AfterDig;
          end else begin
            sreg_next = sreg << 4;
            dcnt_next = dcnt - 1'b1;
          end
        end
      end
      StCr: if (accept) next_state = StLf;
      StLf: if (accept) next_state = StIdle;
      default: next_state = StIdle;
    endcase
  end

endmodule

// File: tb/tb_txhex_fifo.sv
// tb_txhex_fifo: three txhex_fifo configurations driven by shared word
// stimulus, each checked every cycle against a queue-based model of the
// byte stream it must produce.
`timescale 1ns/1ps
module tb_txhex_fifo;

  localparam int N = 3;

  // dut0: defaults; dut1: upper, zero-suppressed, no prefix, "\n"; dut2: 16-bit, depth 2.
  function automatic int unsigned cfg_dw(int i);
    return (i == 2) ? 16 : 32;
  endfunction
  function automatic int unsigned cfg_lg(int i);
    return (i == 2) ? 1 : 2;
  endfunction
  function automatic int unsigned cfg_pre(int i);
    return (i == 1) ? 0 : 1;
  endfunction
  function automatic int unsigned cfg_eol(int i);
    return (i == 1) ? 1 : 2;
  endfunction
  function automatic int unsigned cfg_up(int i);
    return (i == 1) ? 1 : 0;
  endfunction
  function automatic int unsigned cfg_zs(int i);
    return (i == 1) ? 1 : 0;
  endfunction

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stb;
  logic [63:0] data;
  logic        tx_busy [N];
  logic        busy_o [N];
  logic        idle_o [N];
  logic        txs_o [N];
  logic [7:0]  txd_o [N];
  int unsigned fill_o [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int unsigned DWG = cfg_dw(g);
    localparam int unsigned LGG = cfg_lg(g);
    logic [DWG-1:0] d_w;
    logic [LGG:0]   fill_w;
    logic           b_w, i_w, s_w;
    logic [7:0]     t_w;
    assign d_w = data[DWG-1:0];
    txhex_fifo #(
      .DW(DWG), .LGFIFO(LGG), .PREFIX(cfg_pre(g)), .EOL(cfg_eol(g)),
      .UPPER(cfg_up(g)), .ZSUPP(cfg_zs(g))
    ) u_dut (
      .i_clk     (clk),
      .i_reset_n (rst_n),
      .i_stb     (stb),
      .i_data    (d_w),
      .o_busy    (b_w),
      .o_fill    (fill_w),
      .o_idle    (i_w),
      .o_tx_stb  (s_w),
      .o_tx_data (t_w),
      .i_tx_busy (tx_busy[g])
    );
    assign busy_o[g] = b_w;
    assign idle_o[g] = i_w;
    assign txs_o[g]  = s_w;
    assign txd_o[g]  = t_w;
    assign fill_o[g] = 32'(fill_w);
  end

  int n_checks = 0;
  int n_fail   = 0;

  function automatic string vis(string s);
    string r;
    r = "";
    for (int k = 0; k < s.len(); k++) begin
      if (s[k] < 8'h20) r = {r, $sformatf("<%02h>", s[k])};
      else r = {r, $sformatf("%c", s[k])};
    end
    return r;
  endfunction

  function automatic void check(string name, int inst, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s [dut%0d] at %0t: got %0h, expected %0h", name, inst, $time, got, exp);
    end
  endfunction

  function automatic void check_str(string name, int inst, string got, string exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s [dut%0d]: got \"%s\", expected \"%s\"", name, inst, vis(got), vis(exp));
    end
  endfunction

  // ---------------- behavioural model ----------------
  // wq: words waiting in the FIFO. cq: remaining output cycles of the word in
  // flight; bit 8 set marks a silent zero-skip cycle, else bits 7:0 are a byte.
  logic [63:0] wq [N][$];
  logic [8:0]  cq [N][$];
  string       hex_lo = "0123456789abcdef";
  string       hex_up = "0123456789ABCDEF";
  string       crlf;
  string       log_s [N];

  task automatic load_word(int i, logic [63:0] w);
    int unsigned nd;
    bit          lead;
    logic [3:0]  n;
    nd   = cfg_dw(i) / 4;
    lead = 1'b1;
    if (cfg_pre(i) != 0) begin
      cq[i].push_back({1'b0, 8'h30});
      cq[i].push_back({1'b0, 8'h78});
    end
    for (int k = int'(nd) - 1; k >= 0; k--) begin
      n = w[4*k +: 4];
      if (cfg_zs(i) != 0 && lead && n == 4'h0 && k != 0) begin
        cq[i].push_back(9'h100);
      end else begin
        lead = 1'b0;
        cq[i].push_back({1'b0, (cfg_up(i) != 0) ? hex_up[n] : hex_lo[n]});
      end
    end
    if (cfg_eol(i) == 2) cq[i].push_back({1'b0, 8'h0d});
    if (cfg_eol(i) != 0) cq[i].push_back({1'b0, 8'h0a});
  endtask

  function automatic bit model_empty();
    for (int i = 0; i < N; i++) if (wq[i].size() != 0 || cq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // Model advances on the same edge as the DUT, from the inputs alone.
  always @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < N; i++) begin
        bit was_idle, full;
        was_idle = (cq[i].size() == 0);
        full     = (wq[i].size() == (1 << cfg_lg(i)));
        if (!was_idle) begin
          if (cq[i][0][8] || !tx_busy[i]) void'(cq[i].pop_front());
        end
        if (was_idle && wq[i].size() != 0) load_word(i, wq[i].pop_front());
        if (stb && !full) wq[i].push_back(data);
      end
    end
  end

  always @(negedge rst_n) begin
    for (int i = 0; i < N; i++) begin
      wq[i].delete();
      cq[i].delete();
    end
  end

  // ---------------- compare, busy driver, byte log ----------------
  int   busy_mode = 0;  // 0 free, 1 stuck busy, 2 random, 3 busy 3 cycles after accept
  int   hc [N] = '{default: 0};
  logic acc [N] = '{default: 1'b0};
  logic prev_s [N] = '{default: 1'b0};
  logic prev_b [N] = '{default: 1'b0};
  logic [7:0] prev_d [N] = '{default: 8'h00};

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      logic       es;
      logic [7:0] ed;
      int         depth;
      depth = 1 << cfg_lg(i);
      es = (cq[i].size() != 0) && !cq[i][0][8];
      ed = es ? cq[i][0][7:0] : 8'h00;
      check("tx_stb", i, txs_o[i], es);
      check("tx_data", i, txd_o[i], ed);
      check("fill", i, fill_o[i], wq[i].size());
      check("busy", i, busy_o[i], wq[i].size() == depth);
      check("idle", i, idle_o[i], (wq[i].size() == 0) && (cq[i].size() == 0));
      if (rst_n && prev_s[i] && prev_b[i]) begin
        check("hold stb", i, txs_o[i], 1'b1);
        check("hold data", i, txd_o[i], prev_d[i]);
      end
      case (busy_mode)
        0: tx_busy[i] = 1'b0;
        1: tx_busy[i] = 1'b1;
        2: tx_busy[i] = ($urandom_range(0, 2) != 0);
        default: begin
          if (acc[i]) hc[i] = 3;
          tx_busy[i] = (hc[i] > 0);
          if (hc[i] > 0) hc[i]--;
        end
      endcase
      acc[i] = rst_n && txs_o[i] && !tx_busy[i];
      if (acc[i]) log_s[i] = $sformatf("%s%c", log_s[i], txd_o[i]);
      prev_s[i] = rst_n && txs_o[i];
      prev_b[i] = tx_busy[i];
      prev_d[i] = txd_o[i];
    end
  end

  // ---------------- stimulus ----------------
  task automatic clear_logs();
    for (int i = 0; i < N; i++) log_s[i] = "";
  endtask

  // Call at a negedge; returns at the following negedge.
  task automatic push(logic [63:0] w);
    stb  = 1'b1;
    data = w;
    @(negedge clk);
    stb = 1'b0;
  endtask

  task automatic wait_idle(int limit);
    int k;
    k = 0;
    while (!model_empty() && k < limit) begin
      @(negedge clk);
      k++;
    end
    check("drain within budget", 0, k < limit, 1'b1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] w;
    string       e0, e2;
    int          k;
    bit          found;
    crlf  = $sformatf("%c%c", 8'h0d, 8'h0a);
    rst_n = 1'b0;
    stb   = 1'b0;
    data  = '0;
    clear_logs();
    repeat (3) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      check("reset idle", i, idle_o[i], 1'b1);
      check("reset fill", i, fill_o[i], 0);
      check("reset busy", i, busy_o[i], 1'b0);
      check("reset tx_stb", i, txs_o[i], 1'b0);
      check("reset tx_data", i, txd_o[i], 8'h00);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Single word with the UART busy for 3 cycles after every byte.
    busy_mode = 3;
    clear_logs();
    push(64'h1234_5678);
    wait_idle(1000);
    check_str("slow single word", 0, log_s[0], {"0x12345678", crlf});
    check_str("slow single word", 1, log_s[1], "12345678\n");
    check_str("slow single word", 2, log_s[2], {"0x5678", crlf});
    check("idle after word", 0, idle_o[0], 1'b1);

    // Zero suppression and case selection.
    busy_mode = 0;
    clear_logs();
    push(64'h0000_0A0F);
    wait_idle(200);
    push(64'h0);
    wait_idle(200);
    check_str("zsupp words", 1, log_s[1], "A0F\n0\n");
    check_str("zero words", 0, log_s[0], {"0x00000a0f", crlf, "0x00000000", crlf});

    // Fill while the UART is stuck: depth-2 instance drops the third word.
    busy_mode = 1;
    clear_logs();
    push(64'h0);
    push(64'hBEEF);
    push(64'h0001);
    push(64'h1234);
    @(negedge clk);
    check("stuck fill", 2, fill_o[2], 2);
    check("stuck busy", 2, busy_o[2], 1'b1);
    check("stuck fill", 0, fill_o[0], 3);
    check("stuck busy", 0, busy_o[0], 1'b0);
    check("stuck stb held", 0, txs_o[0], 1'b1);

    // Release, then push exactly in dut0's idle gap: push and pop together.
    busy_mode = 0;
    found = 1'b0;
    for (k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      if (!txs_o[0]) found = 1'b1;
    end
    check("idle gap seen", 0, found, 1'b1);
    push(64'h5A5A_5A5A);
    check("push+pop fill", 0, fill_o[0], 3);
    wait_idle(2000);
    check_str("dropped third", 2, log_s[2].substr(0, 23),
              {"0x0000", crlf, "0xbeef", crlf, "0x0001", crlf});

    // Ten words through the FIFO, wrapping its pointers.
    clear_logs();
    e0 = "";
    e2 = "";
    for (int n = 0; n < 10; n++) begin
      w = {$urandom, $urandom};
      push(w);
      e0 = {e0, $sformatf("0x%08h%s", w[31:0], crlf)};
      e2 = {e2, $sformatf("0x%04h%s", w[15:0], crlf)};
      repeat (20) @(negedge clk);
    end
    wait_idle(500);
    check_str("wrap sequence", 0, log_s[0], e0);
    check_str("wrap sequence", 2, log_s[2], e2);

    // Asynchronous reset in the middle of a digit with a backlog queued.
    clear_logs();
    push(64'hCAFE_F00D);
    push(64'h0BAD_BEEF);
    push(64'h1357_9BDF);
    for (k = 0; k < 200 && log_s[0].len() < 5; k++) @(negedge clk);
    check("reached digits", 0, log_s[0].len() >= 5, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
      check("async reset tx_stb", i, txs_o[i], 1'b0);
      check("async reset fill", i, fill_o[i], 0);
    end
    @(negedge clk);
    clear_logs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      check("no bytes after reset", i, log_s[i].len(), 0);
      check("idle after reset", i, idle_o[i], 1'b1);
    end

    // Random traffic with random UART stalls.
    busy_mode = 2;
    for (int n = 0; n < 3000; n++) begin
      stb  = ($urandom_range(0, 3) == 0);
      data = {$urandom, $urandom};
      if ($urandom_range(0, 2) == 0) data = data >> (4 * $urandom_range(0, 15));
      @(negedge clk);
    end
    stb = 1'b0;
    busy_mode = 0;
    wait_idle(3000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
